// File: rtl/xz_scrub_pkg.sv
// Shared types and helpers for the X/Z scrub capture stage.
// Optional drop mode is selected with XZ_SCRUB_DROP_EN.
package xz_scrub_pkg;

   localparam int XZ_W_MAX   = 64;
   localparam int XZ_CNT_MAX = 7;
   localparam int DROP_CNT_W = 8;

   // Sized for the widest legal word; unused upper bits stay 0.
   typedef struct packed {
      logic [XZ_W_MAX-1:0]   data;
      logic [XZ_W_MAX-1:0]   mask;
      logic [XZ_CNT_MAX-1:0] cnt;
   } xz_entry_t;

   function automatic logic [XZ_CNT_MAX-1:0] xz_popcount(
      input logic [XZ_W_MAX-1:0] v
   );
      logic [XZ_CNT_MAX-1:0] c;
      c = '0;
      for (int i = 0; i < XZ_W_MAX; i++) begin
         c = c + XZ_CNT_MAX'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/xz_scrub_lane.sv
// Combinational 4-state to {data, mask, cnt} converter.
// Only case-equality touches the 4-state input.
module xz_scrub_lane
   import xz_scrub_pkg::*;
#(
   parameter int DATA_W = 24
) (
   input  logic [DATA_W-1:0] in_data,
   output xz_entry_t         ent
);

   always_comb begin
      ent = '0;
      for (int i = 0; i < DATA_W; i++) begin
         ent.data[i] = (in_data[i] === 1'b1);
         ent.mask[i] = !((in_data[i] === 1'b1) ||
                         (in_data[i] === 1'b0));
      end
      ent.cnt = xz_popcount(ent.mask);
   end

endmodule

// File: rtl/xz_scrub_fifo.sv
// Show-ahead FIFO of scrubbed 2-state words with X/Z mask and count.
// Define XZ_SCRUB_DROP_EN to discard words containing X/Z.
module xz_scrub_fifo
   import xz_scrub_pkg::*;
#(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_W-1:0]            in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic [DATA_W-1:0]            out_xz_mask,
   output logic [$clog2(DATA_W+1)-1:0]  out_xz_cnt,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic [DROP_CNT_W-1:0]        drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(DATA_W + 1);
   localparam int LW = $clog2(DEPTH + 1);

   xz_entry_t wr_ent;
   xz_entry_t mem_q [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]         level_q, level_d;
   logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [AW-1:0]         wr_idx, rd_idx;
   logic                  empty, full;
   logic                  accept, drop, push, pop;

   xz_scrub_lane #(.DATA_W(DATA_W)) u_lane (
      .in_data (in_data),
      .ent     (wr_ent)
   );

   assign wr_idx = wr_ptr_q[AW-1:0];
   assign rd_idx = rd_ptr_q[AW-1:0];
   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_idx == rd_idx);

   assign in_ready  = !rst && !full;
   assign out_valid = !empty;

   assign accept = in_valid && in_ready;
`ifdef XZ_SCRUB_DROP_EN
   assign drop = accept && (wr_ent.mask != '0);
`else
   assign drop = 1'b0;
`endif
   assign push = accept && !drop;
   assign pop  = out_valid && out_ready;

   always_comb begin
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      level_d    = LW'(wr_ptr_d - rd_ptr_d);
      drop_cnt_d = drop_cnt_q;
`ifdef XZ_SCRUB_DROP_EN
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is never reset; the empty gate below hides stale data.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_idx] <= wr_ent;
      end
   end

   always_comb begin
      out_data    = '0;
      out_xz_mask = '0;
      out_xz_cnt  = '0;
      if (!empty) begin
         out_data    = DATA_W'(mem_q[rd_idx].data);
         out_xz_mask = DATA_W'(mem_q[rd_idx].mask);
         out_xz_cnt  = CW'(mem_q[rd_idx].cnt);
      end
   end

   assign level    = level_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/xz_scrub_fifo.md
# xz_scrub_fifo

Capture stage that sits directly downstream of the 4-state pattern-driving blocks. It accepts 4-state `logic` words over a valid/ready handshake. Each word is converted to a 2-state `bit` word plus a per-bit X/Z mask and a popcount of that mask. The result is buffered in a small show-ahead FIFO for 2-state consumers.

## Interface
Parameters:
- DATA_W, 24: width of the 4-state input word; also the width of the data and mask outputs; range 1..64.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream presents a word.
- in_ready  output  1  stage can accept; equals !full; 0 while rst is high.
- in_data  input  DATA_W  4-state word (`logic`); may contain X/Z.
- out_valid  output  1  head entry present.
- out_ready  input  1  downstream takes the head entry.
- out_data  output  DATA_W  2-state (`bit`) scrubbed word.
- out_xz_mask  output  DATA_W  bit i is 1 when in_data[i] was X or Z.
- out_xz_cnt  output  $clog2(DATA_W+1)  popcount of out_xz_mask.
- level  output  $clog2(DEPTH+1)  current entry count.
- drop_cnt  output  8  saturating count of dropped words; constant 0 when XZ_SCRUB_DROP_EN is undefined.

## Operation
- Accept happens when in_valid && in_ready at a rising edge. Pop happens when out_valid && out_ready.
- Scrub rule, per bit:
  - in_data[i] === 1'b1 gives data bit 1 and mask bit 0.
  - in_data[i] === 1'b0 gives data bit 0 and mask bit 0.
  - X or Z gives data bit 0 and mask bit 1.
  - Use case-equality only. `==`, `if (x)` and reduction operators must not be used on in_data.
- Entry = {data, mask, cnt}. out_xz_cnt is computed at write time and stored; it is not recomputed at the output.
- FIFO:
  - Read and write pointers are log2(DEPTH)+1 bits; the MSB is the wrap flag.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
  - Pointers wrap modulo 2*DEPTH with no special case.
- Show-ahead: out_data, out_xz_mask and out_xz_cnt reflect the head entry whenever out_valid=1. They hold steady while out_valid && !out_ready.
- Simultaneous push and pop:
  - Allowed whenever not full; level is unchanged.
  - When full, in_ready=0, so there is no push. A pop in that cycle makes in_ready=1 in the next cycle. There is no same-cycle bypass.
- When empty, a push does not fall through. out_valid rises in the next cycle.
- Upstream must hold in_data stable while in_valid && !in_ready. The stage does not check this.
- Outputs are 2-state except in_ready, which is driven from registered state and is therefore never X after reset.

## Timing
- Latency from accept to out_valid is 1 cycle when empty. Otherwise the entry waits behind the earlier entries.
- Throughput is 1 word per cycle in steady state with out_ready=1.
- Reset values:
  - in_ready=0 while rst=1, then 1 in the first cycle after rst falls.
  - out_valid=0.
  - out_data, out_xz_mask and out_xz_cnt = 0.
  - level=0.
  - drop_cnt=0.
  - pointers=0.
- Reset mid-operation discards all entries. Storage contents need not be cleared, but the outputs must read 0 while empty.
- level updates one cycle after an accept or pop edge, i.e. it is a registered output.

## Configuration
- `XZ_SCRUB_DROP_EN` defined:
  - A word whose mask is nonzero is still accepted (in_ready unaffected) but is not written into the FIFO.
  - drop_cnt increments by 1, saturating at 255.
  - Words that are fully 0/1 are stored normally.
- Undefined: every accepted word is stored, and drop_cnt is tied to 0.

## Structure
- Package `xz_scrub_pkg`:
  - `typedef struct packed` entry type parameterised through localparams.
  - Helper function `xz_popcount`.
  - Constant `DROP_CNT_W = 8`.
- Sub-module `xz_scrub_lane`: purely combinational. It converts 4-state to {data, mask, cnt} and is instantiated once in front of the write port.
- FIFO storage, pointers and handshake logic live in `xz_scrub_fifo`.

## Test plan
- Reset, then push in_data=24'h00A5C3 with out_ready=1 -> next cycle out_valid=1, out_data=24'h00A5C3, mask=0, cnt=0, level=1.
- Push a word with bits [3:0]=4'bxz10 and all other bits 0 -> out_data[3:0]=4'b0010, out_xz_mask=24'h00000C, out_xz_cnt=2.
- out_ready=0 with 5 pushes at DEPTH=4 -> in_ready=0 after the 4th accept, level=4, and the 5th word is held. One pop makes in_ready=1 in the next cycle, and data comes out in FIFO order.
- Continuous push and pop for 10 cycles -> level stays at 1, and pointers wrap without loss or duplication.
- With `XZ_SCRUB_DROP_EN`: push 3 words, the middle one containing a Z -> only 2 words are output, drop_cnt=1. After 300 X-words, drop_cnt=255.
- Assert rst while level=3 -> next cycle out_valid=0, level=0, and in_ready=1 after release.
